// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : riscv_pkg                                             |
// | Purpose  : Shared constants and types for the 5-stage RISC-V     |
// |            pipeline control path: opcodes, ALU op classes,       |
// |            forwarding selects and the decoded-control bundle.    |
// | Ports    : none (package)                                        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package riscv_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Decoded control bits as produced by the ID-stage decoder.
   typedef struct packed {
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       beq;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_t;

   // The nearer producer (MEM) shadows the older one (WB).
   function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
      if (mem_hit)     return FWD_MEM;
      else if (wb_hit) return FWD_WB;
      else             return FWD_RF;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ctrl_pipe_if                                          |
// | Purpose  : Bundle between the ID stage / datapath and ctrl_pipe. |
// | Ports    : master drives the ID-side inputs and branch result,   |
// |            slave (ctrl_pipe) drives stage controls, forwarding   |
// |            selects, stall/flush and the bubble counter.          |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface ctrl_pipe_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic             mem_to_reg_in;
   logic             reg_write_in;
   logic             mem_read_in;
   logic             mem_write_in;
   logic             beq_instruction_in;
   logic             aluSrc_in;
   logic [1:0]       aluOp_in;
   logic [REG_W-1:0] rd_in;
   logic [REG_W-1:0] rs1_in;
   logic [REG_W-1:0] rs2_in;
   logic             branch_taken;

   logic             ex_aluSrc;
   logic             ex_beq;
   logic [1:0]       ex_aluOp;
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   logic             mem_mem_read;
   logic             mem_mem_write;
   logic             wb_reg_write;
   logic             wb_mem_to_reg;
   logic [REG_W-1:0] wb_rd;
   logic             stall;
   logic             flush;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output id_valid, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in,
             beq_instruction_in, aluSrc_in, aluOp_in, rd_in, rs1_in, rs2_in,
             branch_taken,
      input  ex_aluSrc, ex_beq, ex_aluOp, forward_a, forward_b, mem_mem_read,
             mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_rd, stall, flush,
             bubble_cnt
   );

   modport slave (
      input  id_valid, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in,
             beq_instruction_in, aluSrc_in, aluOp_in, rd_in, rs1_in, rs2_in,
             branch_taken,
      output ex_aluSrc, ex_beq, ex_aluOp, forward_a, forward_b, mem_mem_read,
             mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_rd, stall, flush,
             bubble_cnt
   );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe_forwarding_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : forwarding_unit                                       |
// | Purpose  : Combinational ALU operand forwarding selects for EX.  |
// | Ports    : ex_rs1_i/ex_rs2_i  EX source registers                |
// |            mem_*_i / wb_*_i   producer valid, reg_write, rd      |
// |            forward_a_o/_b_o   00 regfile, 01 WB, 10 MEM          |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module forwarding_unit
   import riscv_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  wire logic [REG_W-1:0] ex_rs1_i,
   input  wire logic [REG_W-1:0] ex_rs2_i,
   input  wire logic             mem_valid_i,
   input  wire logic             mem_reg_write_i,
   input  wire logic [REG_W-1:0] mem_rd_i,
   input  wire logic             wb_valid_i,
   input  wire logic             wb_reg_write_i,
   input  wire logic [REG_W-1:0] wb_rd_i,
   output logic      [1:0]       forward_a_o,
   output logic      [1:0]       forward_b_o
);
   logic w_mem_wr;
   logic w_wb_wr;

   // x0 is hard-wired to zero, so a write to it never produces a value.
   assign w_mem_wr = mem_valid_i & mem_reg_write_i & (mem_rd_i != '0);
   assign w_wb_wr  = wb_valid_i  & wb_reg_write_i  & (wb_rd_i  != '0);

   assign forward_a_o = fwd_select(w_mem_wr && (mem_rd_i == ex_rs1_i),
                                   w_wb_wr  && (wb_rd_i  == ex_rs1_i));
   assign forward_b_o = fwd_select(w_mem_wr && (mem_rd_i == ex_rs2_i),
                                   w_wb_wr  && (wb_rd_i  == ex_rs2_i));
endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ctrl_pipe                                             |
// | Purpose  : Carries decoded controls through EX/MEM/WB, detects   |
// |            load-use stalls and taken-branch flushes, counts      |
// |            inserted bubbles and drives EX forwarding selects.    |
// | Ports    : clock, reset (async, active-high)                     |
// |            ctl  slave side of ctrl_pipe_if                       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module ctrl_pipe
   import riscv_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input wire logic  clock,
   input wire logic  reset,
   ctrl_pipe_if.slave ctl
);
   // EX stage
   logic             ex_valid_q, ex_valid_d;
   ctrl_t            ex_ctrl_q,  ex_ctrl_d;
   logic [REG_W-1:0] ex_rd_q,    ex_rd_d;
   logic [REG_W-1:0] ex_rs1_q,   ex_rs1_d;
   logic [REG_W-1:0] ex_rs2_q,   ex_rs2_d;
   // MEM stage
   logic             mem_valid_q;
   logic             mem_reg_write_q;
   logic             mem_mem_to_reg_q;
   logic             mem_mem_read_q;
   logic             mem_mem_write_q;
   logic [REG_W-1:0] mem_rd_q;
   // WB stage
   logic             wb_valid_q;
   logic             wb_reg_write_q;
   logic             wb_mem_to_reg_q;
   logic [REG_W-1:0] wb_rd_q;

   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   logic w_flush;
   logic w_load_use;
   logic w_stall;
   logic w_bubble;

   assign w_flush    = ex_valid_q & ex_ctrl_q.beq & ctl.branch_taken;
   assign w_load_use = ctl.id_valid & ex_valid_q & ex_ctrl_q.mem_read & (ex_rd_q != '0) &
                       ((ex_rd_q == ctl.rs1_in) | (ex_rd_q == ctl.rs2_in));
   // A flush squashes the ID instruction, so any hazard it had is moot.
   assign w_stall    = w_load_use & ~w_flush;
   assign w_bubble   = w_stall | w_flush;

   always_comb begin
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = '0;
      ex_rd_d      = '0;
      ex_rs1_d     = '0;
      ex_rs2_d     = '0;
      bubble_cnt_d = bubble_cnt_q;
      if (!w_bubble && ctl.id_valid) begin
         ex_valid_d           = 1'b1;
         ex_ctrl_d.mem_to_reg = ctl.mem_to_reg_in;
         ex_ctrl_d.reg_write  = ctl.reg_write_in;
         ex_ctrl_d.mem_read   = ctl.mem_read_in;
         ex_ctrl_d.mem_write  = ctl.mem_write_in;
         ex_ctrl_d.beq        = ctl.beq_instruction_in;
         ex_ctrl_d.alu_src    = ctl.aluSrc_in;
         ex_ctrl_d.alu_op     = ctl.aluOp_in;
         ex_rd_d              = ctl.rd_in;
         ex_rs1_d             = ctl.rs1_in;
         ex_rs2_d             = ctl.rs2_in;
      end
      if (w_bubble && (bubble_cnt_q != {CNT_W{1'b1}}))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_valid_q       <= 1'b0;
         ex_ctrl_q        <= '0;
         ex_rd_q          <= '0;
         ex_rs1_q         <= '0;
         ex_rs2_q         <= '0;
         mem_valid_q      <= 1'b0;
         mem_reg_write_q  <= 1'b0;
         mem_mem_to_reg_q <= 1'b0;
         mem_mem_read_q   <= 1'b0;
         mem_mem_write_q  <= 1'b0;
         mem_rd_q         <= '0;
         wb_valid_q       <= 1'b0;
         wb_reg_write_q   <= 1'b0;
         wb_mem_to_reg_q  <= 1'b0;
         wb_rd_q          <= '0;
         bubble_cnt_q     <= '0;
      end else begin
         ex_valid_q       <= ex_valid_d;
         ex_ctrl_q        <= ex_ctrl_d;
         ex_rd_q          <= ex_rd_d;
         ex_rs1_q         <= ex_rs1_d;
         ex_rs2_q         <= ex_rs2_d;
         mem_valid_q      <= ex_valid_q;
         mem_reg_write_q  <= ex_ctrl_q.reg_write;
         mem_mem_to_reg_q <= ex_ctrl_q.mem_to_reg;
         mem_mem_read_q   <= ex_ctrl_q.mem_read;
         mem_mem_write_q  <= ex_ctrl_q.mem_write;
         mem_rd_q         <= ex_rd_q;
         wb_valid_q       <= mem_valid_q;
         wb_reg_write_q   <= mem_reg_write_q;
         wb_mem_to_reg_q  <= mem_mem_to_reg_q;
         wb_rd_q          <= mem_rd_q;
         bubble_cnt_q     <= bubble_cnt_d;
      end
   end

   // Stage outputs read as zero whenever the stage holds no instruction.
   assign ctl.ex_aluSrc     = ex_valid_q & ex_ctrl_q.alu_src;
   assign ctl.ex_beq        = ex_valid_q & ex_ctrl_q.beq;
   assign ctl.ex_aluOp      = ex_valid_q ? ex_ctrl_q.alu_op : ALUOP_ADD;
   assign ctl.mem_mem_read  = mem_valid_q & mem_mem_read_q;
   assign ctl.mem_mem_write = mem_valid_q & mem_mem_write_q;
   assign ctl.wb_reg_write  = wb_valid_q & wb_reg_write_q;
   assign ctl.wb_mem_to_reg = wb_valid_q & wb_mem_to_reg_q;
   assign ctl.wb_rd         = wb_valid_q ? wb_rd_q : '0;
   assign ctl.stall         = w_stall;
   assign ctl.flush         = w_flush;
   assign ctl.bubble_cnt    = bubble_cnt_q;

   forwarding_unit #(
      .REG_W (REG_W)
   ) u_fwd (
      .ex_rs1_i        (ex_rs1_q),
      .ex_rs2_i        (ex_rs2_q),
      .mem_valid_i     (mem_valid_q),
      .mem_reg_write_i (mem_reg_write_q),
      .mem_rd_i        (mem_rd_q),
      .wb_valid_i      (wb_valid_q),
      .wb_reg_write_i  (wb_reg_write_q),
      .wb_rd_i         (wb_rd_q),
      .forward_a_o     (ctl.forward_a),
      .forward_b_o     (ctl.forward_b)
   );
endmodule
`default_nettype wire
